phase_sampler: RTL and testbench

Run controller and phase-readout stage that sits directly downstream of the recursive coupling matrix. On a start command it drives the matrix's `ising_rstn`, lets the oscillators anneal for a programmed number of `clk` cycles, then samples the asynchronous `bot_row` outputs. Each spin is classified as in-phase or anti-phase relative to the reference oscillator, `bot_row[N-1]`. Results are latched for software readout.

---
 rtl/phase_sampler.sv | 171 +++++++++++++++++
 tb/tb_phase_sampler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sampler.sv
// -----------------------------------------------------------------------------
// phase_sampler
//
// Run controller and phase readout placed after the recursive coupling matrix.
// A run resets the oscillators, lets them anneal for run_time cycles, then
// measures over a 2^WINDOW_LOG2-cycle window how often each spin disagrees
// with the reference oscillator bot_row[N-1]. Spins that disagree on more
// than half of the window read as anti-phase (1).
//
// Ports:
//   clk        - system clock (single domain)
//   axi_rst    - asynchronous active-high reset
//   start      - single-cycle run request, honoured only when idle
//   run_time   - anneal length in cycles, captured on start (0 acts as 1)
//   busy       - high while a run is in progress
//   done       - one-cycle pulse when spins update
//   ising_rstn - active-low oscillator reset to the matrix
//   bot_row    - asynchronous oscillator outputs (synchronized internally)
//   spins      - latched phase result, 1 = anti-phase to bot_row[N-1]
//   rd_addr    - spin index for readback
//   rd_data    - registered readback word (1-cycle latency)
//
// Build option:
//   PHASE_SAMPLER_RAW_COUNT_EN - when defined, the window counts are latched
//   at the end of each run and returned in rd_data[31:1] beside the spin bit.
// -----------------------------------------------------------------------------
module phase_sampler #(
    parameter int N           = 8,
    parameter int RST_CYCLES  = 16,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 axi_rst,
    input  logic                 start,
    input  logic [31:0]          run_time,
    output logic                 busy,
    output logic                 done,
    output logic                 ising_rstn,
    input  logic [N-1:0]         bot_row,
    output logic [N-1:0]         spins,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [31:0]          rd_data
);

    localparam int              CW        = WINDOW_LOG2 + 1;
    localparam logic [31:0]     RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0]     MEAS_LAST = 32'((1 << WINDOW_LOG2) - 1);
    localparam logic [CW-1:0]   HALF      = CW'(1 << (WINDOW_LOG2 - 1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [31:0]   tmr;
    logic [31:0]   run_len;
    logic [N-1:0]  sync1;
    logic [N-1:0]  s_row;
    logic [CW-1:0] cnt [N];
    logic          run_last;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign ising_rstn = (state != S_RST);
    assign run_last   = (state == S_RUN) && (tmr == run_len - 32'd1);

    // Two-flop synchronizer; the 2-cycle lag is intentionally not compensated.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            sync1 <= '0;
            s_row <= '0;
        end else begin
            sync1 <= bot_row;
            s_row <= sync1;
        end
    end

    // One shared timer counts RST, RUN and MEAS phases, restarting at each.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state   <= S_IDLE;
            tmr     <= '0;
            run_len <= 32'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        run_len <= (run_time == 32'd0) ? 32'd1 : run_time;
                        tmr     <= '0;
                        state   <= S_RST;
                    end
                end
                S_RST: begin
                    if (tmr == RST_LAST) begin
                        tmr   <= '0;
                        state <= S_RUN;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_RUN: begin
                    if (run_last) begin
                        tmr   <= '0;
                        state <= S_MEAS;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_MEAS: begin
                    if (tmr == MEAS_LAST) begin
                        tmr   <= '0;
                        state <= S_DONE;
                    end else begin
                        tmr <= tmr + 32'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Disagreement counters: cleared on the RUN->MEAS transition, one extra
    // bit so a full window (2^WINDOW_LOG2) fits without wrapping.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
        end else if (run_last) begin
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
        end else if (state == S_MEAS) begin
            for (int unsigned i = 0; i < N; i++)
                cnt[i] <= cnt[i] + CW'(s_row[i] ^ s_row[N-1]);
        end
    end

    // Strictly more than half the window is required, so a tie reads as 0.
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            spins <= '0;
        end else if (state == S_DONE) begin
            for (int unsigned i = 0; i < N - 1; i++) spins[i] <= (cnt[i] > HALF);
            spins[N-1] <= 1'b0;
        end
    end

    // rd_addr spans exactly N entries because N is a power of two.
`ifdef PHASE_SAMPLER_RAW_COUNT_EN
    logic [CW-1:0] cnt_lat [N];

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int unsigned i = 0; i < N; i++) cnt_lat[i] <= '0;
        end else if (state == S_DONE) begin
            for (int unsigned i = 0; i < N; i++) cnt_lat[i] <= cnt[i];
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) rd_data <= '0;
        else         rd_data <= {31'(cnt_lat[rd_addr]), spins[rd_addr]};
    end
`else
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) rd_data <= '0;
        else         rd_data <= {31'b0, spins[rd_addr]};
    end
`endif

endmodule

// File: tb/tb_phase_sampler.sv
// -----------------------------------------------------------------------------
// tb_phase_sampler
//
// Directed bench for phase_sampler. A reference model derives the expected
// run schedule from the start cycle and run length, and the expected spins
// from a record of every bot_row value driven (shifted by the 2-cycle
// synchronizer lag). A compare process checks all outputs every cycle; the
// main sequence also pins a few hand-computed results.
// -----------------------------------------------------------------------------
module tb_phase_sampler;

    localparam int N           = 8;
    localparam int RST_CYCLES  = 16;
    localparam int WINDOW_LOG2 = 8;
    localparam int WIN         = 1 << WINDOW_LOG2;
    localparam int AW          = $clog2(N);
    localparam int HMAX        = 20000;

    logic          clk = 1'b0;
    logic          axi_rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   run_time = 32'd0;
    logic          busy;
    logic          done;
    logic          ising_rstn;
    logic [N-1:0]  bot_row;
    logic [N-1:0]  spins;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;

    phase_sampler #(
        .N           (N),
        .RST_CYCLES  (RST_CYCLES),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) dut (
        .clk        (clk),
        .axi_rst    (axi_rst),
        .start      (start),
        .run_time   (run_time),
        .busy       (busy),
        .done       (done),
        .ising_rstn (ising_rstn),
        .bot_row    (bot_row),
        .spins      (spins),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- stimulus patterns ----------------
    // 0: all bits follow one square wave
    // 1: as 0, bit 0 inverted
    // 2: as 0, bit 2 inverted for win_n cycles starting at win_lo
    // 3: random
    int mode       = 3;
    int win_lo     = 0;
    int win_n      = 0;
    int fixed_addr = -1;
    logic [N-1:0] hist [HMAX];

    function automatic logic [N-1:0] pattern(input int k);
        logic [N-1:0] v;
        logic sq;
        sq = k[2];
        case (mode)
            0: v = {N{sq}};
            1: begin v = {N{sq}}; v[0] = ~sq; end
            2: begin
                v = {N{sq}};
                if (k >= win_lo && k < win_lo + win_n) v[2] = ~sq;
            end
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        bot_row = pattern(cyc);
        if (cyc < HMAX) hist[cyc] = bot_row;
        rd_addr = (fixed_addr >= 0) ? AW'(fixed_addr) : AW'(cyc);
    end

    // ---------------- reference model + compare ----------------
    logic         active = 1'b0;
    int           c0 = 0;
    int           rlen = 1;
    int           dcyc;
    int           mstart;
    int           cnt_acc;
    int           exp_cnt [N];
    logic [N-1:0] exp_spins = '0;
    logic [31:0]  exp_rd = '0;
    logic [N-1:0] b;
    int           done_count = 0;
    int           last_done = -1;

    always @(negedge clk) begin
        if (axi_rst) begin
            active    = 1'b0;
            exp_spins = '0;
            exp_rd    = '0;
            for (int i = 0; i < N; i++) exp_cnt[i] = 0;
            check("rst_busy",       {31'b0, busy},       32'd0);
            check("rst_done",       {31'b0, done},       32'd0);
            check("rst_ising_rstn", {31'b0, ising_rstn}, 32'd1);
            check("rst_spins",      32'(spins),          32'd0);
            check("rst_rd_data",    rd_data,             32'd0);
        end else begin
            dcyc = c0 + 1 + RST_CYCLES + rlen + WIN;
            check("busy",       {31'b0, busy},
                  {31'b0, active && cyc > c0 && cyc <= dcyc});
            check("done",       {31'b0, done},
                  {31'b0, active && cyc == dcyc});
            check("ising_rstn", {31'b0, ising_rstn},
                  {31'b0, !(active && cyc > c0 && cyc <= c0 + RST_CYCLES)});
            check("spins",      32'(spins), 32'(exp_spins));
            check("rd_data",    rd_data, exp_rd);

`ifdef PHASE_SAMPLER_RAW_COUNT_EN
            exp_rd = (32'(exp_cnt[rd_addr]) << 1) | 32'(exp_spins[rd_addr]);
`else
            exp_rd = 32'(exp_spins[rd_addr]);
`endif
            if (done) begin
                done_count++;
                last_done = cyc;
            end

            if (active && cyc == dcyc) begin
                // Window covers MEAS cycles; s_row there is bot_row from 2 cycles earlier.
                mstart = c0 + 1 + RST_CYCLES + rlen - 2;
                for (int i = 0; i < N; i++) begin
                    cnt_acc = 0;
                    for (int k = 0; k < WIN; k++) begin
                        b = hist[mstart + k];
                        cnt_acc += int'(b[i] ^ b[N-1]);
                    end
                    exp_cnt[i]   = cnt_acc;
                    exp_spins[i] = (i != N - 1) && (cnt_acc > WIN / 2);
                end
                active = 1'b0;
            end else if (!active && start) begin
                active = 1'b1;
                c0     = cyc;
                rlen   = (run_time == 32'd0) ? 1 : int'(run_time);
            end
        end
    end

    // ---------------- directed sequence ----------------
    // Starts a run; optionally pokes start at offset poke_at (run_time 50)
    // and/or asserts reset for 2 cycles at offset rst_at. Returns with the
    // new results visible (cycle after done) or after the aborted run.
    task automatic do_run(input int rt, input int poke_at, input int rst_at, output int sc);
        int t;
        @(posedge clk); #1;
        start    = 1'b1;
        run_time = 32'(rt);
        sc       = cyc;
        if (mode == 2) win_lo = sc + RST_CYCLES + rt - 1;
        @(posedge clk); #1;
        start    = 1'b0;
        run_time = 32'hDEAD_BEEF;
        t = 1;
        while (active && t < 2000) begin
            start = (t == poke_at);
            if (t == poke_at) run_time = 32'd50;
            if (t == rst_at) axi_rst = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check("run_timeout", {31'b0, t < 2000}, 32'd1);
        if (axi_rst) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            axi_rst = 1'b0;
        end
    endtask

    int sc;
    int dc_before;

    initial begin
        // Reset with random bot_row activity.
        mode = 3;
        repeat (6) @(posedge clk);
        #1 axi_rst = 1'b0;

        // All in phase: done at cycle 283 relative to start.
        mode = 0;
        dc_before = done_count;
        do_run(10, 0, 0, sc);
        check("lit_done_cycle", 32'(last_done - sc), 32'd283);
        check("lit_done_count", 32'(done_count - dc_before), 32'd1);
        check("lit_spins_inphase", 32'(spins), 32'h00);

        // One inverted bit, with readback of spin 0.
        mode = 1;
        fixed_addr = 0;
        do_run(10, 0, 0, sc);
        check("lit_spins_inv0", 32'(spins), 32'h01);
        @(posedge clk); #1;
`ifdef PHASE_SAMPLER_RAW_COUNT_EN
        check("lit_rd_inv0", rd_data, 32'h201);
`else
        check("lit_rd_inv0", rd_data, 32'h1);
`endif
        fixed_addr = -1;

        // Tie (128 of 256) then one over (129).
        mode = 2;
        win_n = 128;
        do_run(10, 0, 0, sc);
        check("lit_spins_tie", 32'(spins), 32'h00);
        win_n = 129;
        do_run(12, 0, 0, sc);
        check("lit_spins_tie_plus1", 32'(spins), 32'h04);

        // Start while busy (during RUN) is ignored.
        mode = 1;
        dc_before = done_count;
        do_run(10, 20, 0, sc);
        check("lit_busy_done_cycle", 32'(last_done - sc), 32'd283);
        check("lit_busy_done_count", 32'(done_count - dc_before), 32'd1);

        // Reset mid-MEAS, then a normal run.
        mode = 1;
        dc_before = done_count;
        do_run(10, 0, 100, sc);
        check("lit_abort_done_count", 32'(done_count - dc_before), 32'd0);
        check("lit_abort_spins", 32'(spins), 32'h00);
        do_run(10, 0, 0, sc);
        check("lit_after_abort_spins", 32'(spins), 32'h01);

        // Random patterns, including run_time 0 (acts as 1).
        mode = 3;
        dc_before = done_count;
        do_run(0, 0, 0, sc);
        check("lit_rt0_done_cycle", 32'(last_done - sc), 32'd274);
        do_run(3, 0, 0, sc);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
